// File: rtl/cdb_multi_arb_pkg.sv
// Shared types and constants for the multi-port completion/writeback arbiter.
package cdb_multi_arb_pkg;

  localparam int CDB_NUM_FU = 4;
  localparam int CDB_NUM_WB = 2;
  localparam int CDB_SRC_W  = $clog2(CDB_NUM_FU);

  localparam int ROB_IDX_W = 6;
  localparam int PRD_W     = 7;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PRD_W-1:0]     prd;
    logic [XLEN-1:0]      data;
    logic                 exc;
  } fu_wb_t;

  // Round-robin successor of a channel; channel 0 is skipped when it is pinned.
  function automatic int rr_next(input int ch, input int num_fu, input bit pin0);
    int n;
    n = ch + 1;
    if (n >= num_fu) n = pin0 ? 1 : 0;
    return n;
  endfunction

endpackage

// File: rtl/cdb_chan_fifo.sv
// Per-channel completion FIFO with push/pop/flush and a separately kept occupancy count.
module cdb_chan_fifo
  import cdb_multi_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fu_wb_t           din,
  output fu_wb_t           dout,
  output logic [CNT_W-1:0] cnt,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fu_wb_t           mem_q [DEPTH];
  fu_wb_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem_q[rd_ptr_q];
  assign cnt     = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/cdb_multi_arb.sv
// Multi-port writeback arbiter: NUM_FU buffered completion channels onto NUM_WB
// compacted writeback ports, fixed or round-robin priority, optional pinned BRU.
module cdb_multi_arb
  import cdb_multi_arb_pkg::*;
#(
  parameter int NUM_FU     = CDB_NUM_FU,
  parameter int NUM_WB     = CDB_NUM_WB,
  parameter int FIFO_DEPTH = 2,
  parameter int RR_MODE    = 1,
  parameter int PIN_FU0    = 1,
  parameter int SRC_W      = $clog2(NUM_FU),
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic   [NUM_FU-1:0]              fu_valid,
  output logic   [NUM_FU-1:0]              fu_ready,
  input  fu_wb_t [NUM_FU-1:0]              fu_pkt,
  output logic   [NUM_WB-1:0]              wb_valid,
  input  logic   [NUM_WB-1:0]              wb_ready,
  output fu_wb_t [NUM_WB-1:0]              wb_pkt,
  output logic   [NUM_WB-1:0][SRC_W-1:0]   wb_src,
  input  logic                             flush,
  output logic   [NUM_FU-1:0][CNT_W-1:0]   fifo_cnt
);

  localparam int RR_BASE = (PIN_FU0 != 0) ? 1 : 0;
  localparam int RR_NUM  = NUM_FU - RR_BASE;

  logic   [NUM_FU-1:0]            empty, full, pop, cand, taken;
  fu_wb_t [NUM_FU-1:0]            head;
  logic   [NUM_FU-1:0][SRC_W-1:0] rank_ch;
  logic   [SRC_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic   [NUM_WB-1:0]            sel_vld;
  logic   [NUM_WB-1:0][SRC_W-1:0] sel_ch;
  logic                           found;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_chan
    assign fu_ready[i] = !full[i] && !flush;

    cdb_chan_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fu_valid[i] && fu_ready[i]),
      .pop   (pop[i]),
      .flush (flush),
      .din   (fu_pkt[i]),
      .dout  (head[i]),
      .cnt   (fifo_cnt[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  // rank_ch[r] is the channel holding rank r this cycle, whether or not it is non-empty.
  for (genvar r = 0; r < NUM_FU; r++) begin : g_rank
    if (PIN_FU0 != 0 && r == 0) begin : g_pin
      assign rank_ch[r] = '0;
    end else if (RR_MODE != 0) begin : g_rr
      assign rank_ch[r] = SRC_W'(RR_BASE + ((int'(rr_ptr_q) - RR_BASE + r - RR_BASE) % RR_NUM));
    end else begin : g_fix
      assign rank_ch[r] = SRC_W'(r);
    end
    assign cand[r] = !empty[rank_ch[r]] && !flush;
  end

  // Port k takes the k-th non-empty rank, which keeps the ports compacted.
  always_comb begin
    taken   = '0;
    sel_vld = '0;
    sel_ch  = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      found = 1'b0;
      for (int r = 0; r < NUM_FU; r++) begin
        if (!found && cand[r] && !taken[r]) begin
          found      = 1'b1;
          taken[r]   = 1'b1;
          sel_vld[k] = 1'b1;
          sel_ch[k]  = rank_ch[r];
        end
      end
    end
  end

  always_comb begin
    wb_valid = sel_vld;
    wb_pkt   = '0;
    wb_src   = '0;
    pop      = '0;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < NUM_WB; k++) begin
      if (sel_vld[k]) begin
        wb_pkt[k] = head[sel_ch[k]];
        wb_src[k] = sel_ch[k];
        if (wb_ready[k]) begin
          pop[sel_ch[k]] = 1'b1;
          // Ports are in rank order, so the last hit here is the last RR channel popped.
          if (RR_MODE != 0 && !(PIN_FU0 != 0 && sel_ch[k] == '0))
            rr_ptr_d = SRC_W'(rr_next(int'(sel_ch[k]), NUM_FU, PIN_FU0 != 0));
        end
      end
    end
    if (flush) rr_ptr_d = SRC_W'(RR_BASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= SRC_W'(RR_BASE);
    else        rr_ptr_q <= rr_ptr_d;
  end

  for (genvar i = 0; i < NUM_FU; i++) begin : g_chk_fu
    a_valid_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (fu_valid[i] && !fu_ready[i] && !flush) |=> fu_valid[i]);
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
      fifo_cnt[i] <= CNT_W'(FIFO_DEPTH));
  end

  for (genvar k = 1; k < NUM_WB; k++) begin : g_chk_wb
    a_compact: assert property (@(posedge clk) disable iff (!rst_n)
      wb_valid[k] |-> wb_valid[k-1]);
    for (genvar j = 0; j < k; j++) begin : g_uniq
      a_unique_src: assert property (@(posedge clk) disable iff (!rst_n)
        (wb_valid[k] && wb_valid[j]) |-> (wb_src[k] != wb_src[j]));
    end
  end

endmodule

// File: tb/tb_cdb_multi_arb.sv
// Self-checking bench for cdb_multi_arb (4 channels, 2 ports, depth 2, RR with pinned BRU).
module tb_cdb_multi_arb;
  import cdb_multi_arb_pkg::*;

  typedef struct {
    int     ch;
    fu_wb_t pkt;
  } sb_t;

  logic                 clk;
  logic                 rst_n;
  logic   [3:0]         fu_valid;
  logic   [3:0]         fu_ready;
  fu_wb_t [3:0]         fu_pkt;
  logic   [1:0]         wb_valid;
  logic   [1:0]         wb_ready;
  fu_wb_t [1:0]         wb_pkt;
  logic   [1:0][1:0]    wb_src;
  logic                 flush;
  logic   [3:0][1:0]    fifo_cnt;

  sb_t sb[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  cdb_multi_arb #(
    .NUM_FU     (4),
    .NUM_WB     (2),
    .FIFO_DEPTH (2),
    .RR_MODE    (1),
    .PIN_FU0    (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fu_valid (fu_valid),
    .fu_ready (fu_ready),
    .fu_pkt   (fu_pkt),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_pkt   (wb_pkt),
    .wb_src   (wb_src),
    .flush    (flush),
    .fifo_cnt (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic fu_wb_t mk_pkt(input int ch, input logic [5:0] rob);
    fu_wb_t p;
    p.rob_idx = rob;
    p.prd     = 7'(ch * 16 + int'(rob));
    p.data    = $urandom;
    p.exc     = rob[0];
    return p;
  endfunction

  task automatic push(input int ch, input logic [5:0] rob);
    sb_t e;
    e.ch  = ch;
    e.pkt = mk_pkt(ch, rob);
    fu_valid[ch] = 1'b1;
    fu_pkt[ch]   = e.pkt;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n        = 0;
    fu_valid = '0;
    wb_ready = 2'b11;
    while (fifo_cnt != '0 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 64'(fifo_cnt), 64'd0);
  endtask

  // Scoreboard: every accepted writeback must be the oldest outstanding packet of its channel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (wb_valid[k] && wb_ready[k]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].ch == int'(wb_src[k])) idx = i;
          if (idx < 0) begin
            chk("sb_unexpected_wb", 64'(wb_src[k]), 64'hFF);
          end else begin
            chk("sb_pkt", 64'(wb_pkt[k]), 64'(sb[idx].pkt));
            sb.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    int g;
    int e0, e1;
    fu_wb_t p20, p21;

    rst_n    = 1'b0;
    fu_valid = '0;
    fu_pkt   = '0;
    wb_ready = '0;
    flush    = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    chk("rst_wb_pkt0", 64'(wb_pkt[0]), 64'd0);
    chk("rst_wb_pkt1", 64'(wb_pkt[1]), 64'd0);
    chk("rst_wb_src", 64'(wb_src), 64'd0);
    rst_n = 1'b1;
    chk("rst_fu_ready", 64'(fu_ready), 64'hF);

    // Priority: channels 1,2,3 push together, 2 ports
    wb_ready = 2'b11;
    push(1, 6'd5);
    push(2, 6'd6);
    push(3, 6'd7);
    @(negedge clk);
    chk("lat_no_comb", 64'(wb_valid), 64'd0);
    step();
    fu_valid = '0;
    @(negedge clk);
    chk("pri_c1_valid", 64'(wb_valid), 64'd3);
    chk("pri_c1_src0", 64'(wb_src[0]), 64'd1);
    chk("pri_c1_src1", 64'(wb_src[1]), 64'd2);
    chk("pri_c1_rob0", 64'(wb_pkt[0].rob_idx), 64'd5);
    chk("pri_c1_rob1", 64'(wb_pkt[1].rob_idx), 64'd6);
    step();
    @(negedge clk);
    chk("pri_c2_valid", 64'(wb_valid), 64'd1);
    chk("pri_c2_src0", 64'(wb_src[0]), 64'd3);
    chk("pri_c2_rob0", 64'(wb_pkt[0].rob_idx), 64'd7);
    chk("pri_c2_src1_idle", 64'(wb_src[1]), 64'd0);
    chk("pri_c2_pkt1_idle", 64'(wb_pkt[1]), 64'd0);
    step();
    @(negedge clk);
    chk("pri_c3_valid", 64'(wb_valid), 64'd0);

    // Round-robin fairness, channels 1-3 kept busy, BRU preempts once
    g = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      fu_valid = '0;
      for (int ch = 1; ch < 4; ch++)
        if (fu_ready[ch]) push(ch, 6'(16 + c));
      if (c == 4) begin
        chk("rr_bru_ready", 64'(fu_ready[0]), 64'd1);
        push(0, 6'd63);
      end
      @(negedge clk);
      if (c > 0) begin
        if (c == 5) begin
          e0 = 0;
          e1 = 1 + (g % 3);
          g  = g + 1;
        end else begin
          e0 = 1 + (g % 3);
          e1 = 1 + ((g + 1) % 3);
          g  = g + 2;
        end
        chk("rr_valid", 64'(wb_valid), 64'd3);
        chk("rr_src0", 64'(wb_src[0]), 64'(e0));
        chk("rr_src1", 64'(wb_src[1]), 64'(e1));
      end
    end
    step();
    drain("rr_drain");

    // Backpressure on channel 2
    wb_ready = 2'b00;
    push(2, 6'd20);
    p20 = fu_pkt[2];
    @(negedge clk);
    step();
    chk("bp_ready_b1", 64'(fu_ready[2]), 64'd1);
    push(2, 6'd21);
    p21 = fu_pkt[2];
    @(negedge clk);
    chk("bp_b1_pkt", 64'(wb_pkt[0]), 64'(p20));
    for (int b = 2; b < 4; b++) begin
      step();
      fu_valid = '0;
      @(negedge clk);
      chk("bp_full_ready", 64'(fu_ready[2]), 64'd0);
      chk("bp_full_cnt", 64'(fifo_cnt[2]), 64'd2);
      chk("bp_hold_pkt", 64'(wb_pkt[0]), 64'(p20));
      chk("bp_hold_src", 64'(wb_src[0]), 64'd2);
    end
    step();
    wb_ready = 2'b11;
    @(negedge clk);
    chk("bp_rel_first", 64'(wb_pkt[0]), 64'(p20));
    step();
    @(negedge clk);
    chk("bp_rel_second", 64'(wb_pkt[0]), 64'(p21));
    step();
    drain("bp_drain");

    // Same-cycle push and pop on channel 1
    push(1, 6'd30);
    @(negedge clk);
    step();
    chk("pp_ready", 64'(fu_ready[1]), 64'd1);
    push(1, 6'd31);
    @(negedge clk);
    chk("pp_cnt_before", 64'(fifo_cnt[1]), 64'd1);
    chk("pp_head_old", 64'(wb_pkt[0].rob_idx), 64'd30);
    step();
    fu_valid = '0;
    @(negedge clk);
    chk("pp_cnt_after", 64'(fifo_cnt[1]), 64'd1);
    chk("pp_head_new", 64'(wb_pkt[0].rob_idx), 64'd31);
    step();
    @(negedge clk);
    chk("pp_empty", 64'(fifo_cnt[1]), 64'd0);

    // Flush with three loaded channels and inputs valid during the flush
    step();
    wb_ready = 2'b00;
    push(1, 6'd40);
    push(2, 6'd41);
    push(3, 6'd42);
    @(negedge clk);
    step();
    fu_valid = '0;
    @(negedge clk);
    chk("fl_loaded_cnt", 64'(fifo_cnt), 64'h54);
    chk("fl_loaded_valid", 64'(wb_valid), 64'd3);
    step();
    flush    = 1'b1;
    wb_ready = 2'b11;
    sb.delete();
    fu_valid = 4'b1110;
    fu_pkt[1] = mk_pkt(1, 6'd50);
    fu_pkt[2] = mk_pkt(2, 6'd51);
    fu_pkt[3] = mk_pkt(3, 6'd52);
    @(negedge clk);
    chk("fl_wb_valid", 64'(wb_valid), 64'd0);
    chk("fl_fu_ready", 64'(fu_ready), 64'd0);
    step();
    flush    = 1'b0;
    fu_valid = '0;
    @(negedge clk);
    chk("fl_after_cnt", 64'(fifo_cnt), 64'd0);
    chk("fl_after_valid", 64'(wb_valid), 64'd0);
    step();
    @(negedge clk);
    chk("fl_quiet", 64'(wb_valid), 64'd0);

    // Asynchronous reset mid-drain
    step();
    push(1, 6'd60);
    push(2, 6'd61);
    push(3, 6'd62);
    @(negedge clk);
    step();
    fu_valid = '0;
    @(negedge clk);
    step();
    #2;
    chk("rs_pre_valid", 64'(wb_valid), 64'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rs_async_valid", 64'(wb_valid), 64'd0);
    chk("rs_async_cnt", 64'(fifo_cnt), 64'd0);
    step();
    rst_n = 1'b1;
    chk("rs_rel_ready", 64'(fu_ready), 64'hF);
    push(2, 6'd7);
    @(negedge clk);
    chk("rs_first_lat", 64'(wb_valid), 64'd0);
    step();
    fu_valid = '0;
    @(negedge clk);
    chk("rs_first_valid", 64'(wb_valid), 64'd1);
    chk("rs_first_src", 64'(wb_src[0]), 64'd2);
    chk("rs_first_rob", 64'(wb_pkt[0].rob_idx), 64'd7);
    step();
    drain("rs_drain");
    chk("sb_leftover", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
